ddr_lane_read_training_ctrl: RTL
================================

Name: ddr_lane_read_training_ctrl

Overview:
- Parametrised read-training controller for one DDR4 byte lane of NUM_DQ bits.
- Drives the per-bit IOD delay-line controls (LOAD/MOVE/DIRECTION) to sweep all taps while comparing deserialised RX_DATA against a fixed training pattern.
- Records the widest passing window per bit, then walks each bit back to its own window centre.
- Sits in the fabric next to the lane IOD instances; all logic is clocked by FAB_CLK.

Parameters:
- NUM_DQ, 8, DQ bits per lane.
- DATA_WIDTH, 8, deserialised bits per DQ per FAB_CLK.
- TAP_BITS, 7, width of the tap counter.
- MAX_TAPS, 128, taps swept; must be <= 2^TAP_BITS.
- SETTLE_CYCLES, 4, wait after each LOAD/MOVE before sampling; must be >= 1.
- SAMPLE_CYCLES, 16, consecutive words compared per tap; must be >= 1.
- PATTERN, 8'h55, expected DATA_WIDTH-bit word on every DQ.

Ports:
- FAB_CLK  in  1  sole clock.
- RX_SYNC_RST  in  1  synchronous, active-high reset.
- TRAIN_START  in  1  one-cycle request; ignored unless IDLE or DONE.
- RX_DATA  in  NUM_DQ*DATA_WIDTH  DQ i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- DELAY_LINE_OUT_OF_RANGE  in  NUM_DQ  per-bit out-of-range flag from the IOD.
- DELAY_LINE_LOAD  out  NUM_DQ  one-cycle pulse; loads tap 0.
- DELAY_LINE_MOVE  out  NUM_DQ  one-cycle step pulse.
- DELAY_LINE_DIRECTION  out  NUM_DQ  1 = increment, 0 = decrement; valid with MOVE.
- TRAIN_BUSY  out  1  high in every state except IDLE and DONE.
- TRAIN_DONE  out  1  level; high in DONE.
- TRAIN_ERR  out  NUM_DQ  bit had no passing tap; valid while TRAIN_DONE.
- CENTER_TAP  out  NUM_DQ*TAP_BITS  final tap per bit; valid while TRAIN_DONE.

Behaviour:
- Reset: one clock domain (FAB_CLK), synchronous active-high reset (RX_SYNC_RST).
- Reset values: all outputs 0 and FSM in IDLE. Reset mid-sweep aborts in the next cycle and clears all window state; the IOD taps are left wherever they are.
- States: IDLE, LOAD, SETTLE, SAMPLE, RECORD, STEP, CENTER, WALK, GAP, DONE.
- IDLE/DONE --TRAIN_START--> LOAD.
- LOAD (1 cycle):
  - DELAY_LINE_LOAD = all ones.
  - tap = 0; per-bit run/best registers cleared; TRAIN_DONE and TRAIN_ERR cleared.
  - Go to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE:
  - Runs SAMPLE_CYCLES cycles.
  - Per-bit pass flag starts at 1 and is ANDed with (word == PATTERN) each cycle.
- RECORD (1 cycle), per bit:
  - Pass: if run_len == 0 then run_start = tap; run_len++.
  - Fail: run_len = 0.
  - If the new run_len > best_len, copy run into best. Ties keep the earlier window.
  - Next state:
    - CENTER if tap == MAX_TAPS-1 or any DELAY_LINE_OUT_OF_RANGE bit is set.
    - Otherwise STEP.
- STEP (1 cycle): MOVE = all ones, DIRECTION = all ones, tap++, then SETTLE.
- CENTER (1 cycle), per bit:
  - centre = best_start + ((best_len-1) >> 1), computed in TAP_BITS.
  - best_len == 0: TRAIN_ERR[i] = 1 and centre = 0.
  - cur_tap[i] = tap for every bit.
- WALK (1 cycle):
  - For every bit with cur_tap > centre: MOVE[i] = 1, DIRECTION[i] = 0, cur_tap[i]--.
  - Other bits: MOVE[i] = 0.
  - Always followed by GAP (1 cycle, all MOVE low), so there is at least one idle cycle between pulses.
  - After GAP: if all cur_tap == centre go to DONE, else WALK.
- Worst-case walk: (MAX_TAPS-1) pulses.
- DONE: TRAIN_DONE = 1; CENTER_TAP = centre registers. Hold until TRAIN_START or reset.
- LOAD, MOVE and DIRECTION are never asserted outside LOAD, STEP and WALK. MOVE and LOAD are never asserted in the same cycle.
- TRAIN_START while busy is ignored.

Optional Feature:
- Macro: READ_TRAINING_EYE_MONITOR_EN.
- Defined:
  - Adds inputs EYE_MONITOR_EARLY[NUM_DQ] and EYE_MONITOR_LATE[NUM_DQ], and output EYE_MONITOR_CLEAR_FLAGS[NUM_DQ].
  - CLEAR_FLAGS = all ones for the first SETTLE cycle at each tap.
  - A bit passes a tap only if the pattern matched AND no EARLY or LATE flag was seen at any time during SAMPLE.
- Undefined: none of these ports exist, and pass is pattern-match only.

Test Plan:
- Ideal lane:
  - Stimulus: MAX_TAPS = 128; every bit matches PATTERN for taps 40..79, fails elsewhere.
  - Required: CENTER_TAP = 59 on all bits; TRAIN_ERR = 0; 127 increment pulses, then 68 decrement pulses per bit.
- Per-bit skew:
  - Stimulus: bit 0 window 10..29, bit 7 window 100..127.
  - Required: CENTER_TAP[0] = 19 and [7] = 113; bit 7 stops walking after 14 decrements while bit 0 continues.
- Two windows:
  - Stimulus: passes at 5..14 and 60..89.
  - Required: centre = 74. With equal windows 5..14 and 60..69, centre = 9 (earlier window wins).
- Dead bit:
  - Stimulus: bit 3 never matches.
  - Required: TRAIN_ERR = 8'h08; CENTER_TAP[3] = 0 after 127 decrements.
- Out-of-range abort:
  - Stimulus: DELAY_LINE_OUT_OF_RANGE[2] rises at tap 50; window 20..39.
  - Required: sweep ends at tap 50; centre = 29; no further increments.
- Reset mid-WALK:
  - Stimulus: RX_SYNC_RST for 1 cycle.
  - Required: next cycle all outputs 0 and state IDLE; a following TRAIN_START restarts with a LOAD pulse.

Source files
------------

// File: rtl/ddr_lane_read_training_ctrl.sv
// Read-training controller for one DDR4 byte lane: sweeps IOD taps, finds the widest passing
// window per DQ bit and walks each bit back to its window centre. Optional: READ_TRAINING_EYE_MONITOR_EN.
module ddr_lane_read_training_ctrl #(
    parameter int unsigned NUM_DQ        = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TAP_BITS      = 7,
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLE_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] PATTERN = 8'h55
) (
    input  logic                         FAB_CLK,
    input  logic                         RX_SYNC_RST,
    input  logic                         TRAIN_START,
    input  logic [NUM_DQ*DATA_WIDTH-1:0] RX_DATA,
    input  logic [NUM_DQ-1:0]            DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_DQ-1:0]            DELAY_LINE_LOAD,
    output logic [NUM_DQ-1:0]            DELAY_LINE_MOVE,
    output logic [NUM_DQ-1:0]            DELAY_LINE_DIRECTION,
    output logic                         TRAIN_BUSY,
    output logic                         TRAIN_DONE,
    output logic [NUM_DQ-1:0]            TRAIN_ERR,
`ifdef READ_TRAINING_EYE_MONITOR_EN
    input  logic [NUM_DQ-1:0]            EYE_MONITOR_EARLY,
    input  logic [NUM_DQ-1:0]            EYE_MONITOR_LATE,
    output logic [NUM_DQ-1:0]            EYE_MONITOR_CLEAR_FLAGS,
`endif
    output logic [NUM_DQ*TAP_BITS-1:0]   CENTER_TAP
);

    localparam int unsigned LEN_W   = TAP_BITS + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_RECORD,
        S_STEP, S_CENTER, S_WALK, S_GAP, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAP_BITS-1:0] tap_q, tap_d;
    logic [NUM_DQ-1:0]   pass_q, pass_d;
    logic [NUM_DQ-1:0]   err_q, err_d;
    logic [TAP_BITS-1:0] run_start_q [NUM_DQ];
    logic [TAP_BITS-1:0] run_start_d [NUM_DQ];
    logic [LEN_W-1:0]    run_len_q   [NUM_DQ];
    logic [LEN_W-1:0]    run_len_d   [NUM_DQ];
    logic [TAP_BITS-1:0] best_start_q[NUM_DQ];
    logic [TAP_BITS-1:0] best_start_d[NUM_DQ];
    logic [LEN_W-1:0]    best_len_q  [NUM_DQ];
    logic [LEN_W-1:0]    best_len_d  [NUM_DQ];
    logic [TAP_BITS-1:0] centre_q    [NUM_DQ];
    logic [TAP_BITS-1:0] centre_d    [NUM_DQ];
    logic [TAP_BITS-1:0] cur_tap_q   [NUM_DQ];
    logic [TAP_BITS-1:0] cur_tap_d   [NUM_DQ];

    logic [NUM_DQ-1:0]   load_q, load_d;
    logic [NUM_DQ-1:0]   move_q, move_d;
    logic [NUM_DQ-1:0]   dir_q, dir_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_DQ-1:0]   clear_q, clear_d;

    logic [NUM_DQ-1:0]   match_c;
    logic [LEN_W-1:0]    new_len;
    logic [TAP_BITS-1:0] new_start;
    logic                all_at;

    // Per-bit sample qualifier: pattern match, optionally gated by the eye-monitor flags
    always_comb begin
        for (int i = 0; i < NUM_DQ; i++) begin
`ifdef READ_TRAINING_EYE_MONITOR_EN
            match_c[i] = (RX_DATA[i*DATA_WIDTH +: DATA_WIDTH] == PATTERN)
                         && !EYE_MONITOR_EARLY[i] && !EYE_MONITOR_LATE[i];
`else
            match_c[i] = (RX_DATA[i*DATA_WIDTH +: DATA_WIDTH] == PATTERN);
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tap_d     = tap_q;
        pass_d    = pass_q;
        err_d     = err_q;
        new_len   = '0;
        new_start = '0;
        all_at    = 1'b1;
        load_d    = '0;
        move_d    = '0;
        dir_d     = '0;
        clear_d   = '0;
        for (int i = 0; i < NUM_DQ; i++) begin
            run_start_d[i]  = run_start_q[i];
            run_len_d[i]    = run_len_q[i];
            best_start_d[i] = best_start_q[i];
            best_len_d[i]   = best_len_q[i];
            centre_d[i]     = centre_q[i];
            cur_tap_d[i]    = cur_tap_q[i];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (TRAIN_START) state_d = S_LOAD;
            end
            S_LOAD: begin
                tap_d = '0;
                cnt_d = '0;
                err_d = '0;
                for (int i = 0; i < NUM_DQ; i++) begin
                    run_start_d[i]  = '0;
                    run_len_d[i]    = '0;
                    best_start_d[i] = '0;
                    best_len_d[i]   = '0;
                    centre_d[i]     = '0;
                end
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    pass_d  = '1;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                pass_d = pass_q & match_c;
                if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RECORD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RECORD: begin
                // Extend or break the current run; strictly-longer runs replace best, so ties keep the earlier window
                for (int i = 0; i < NUM_DQ; i++) begin
                    if (pass_q[i]) begin
                        new_start = (run_len_q[i] == '0) ? tap_q : run_start_q[i];
                        new_len   = run_len_q[i] + LEN_W'(1);
                    end else begin
                        new_start = run_start_q[i];
                        new_len   = '0;
                    end
                    run_start_d[i] = new_start;
                    run_len_d[i]   = new_len;
                    if (new_len > best_len_q[i]) begin
                        best_start_d[i] = new_start;
                        best_len_d[i]   = new_len;
                    end
                end
                if ((tap_q == TAP_BITS'(MAX_TAPS - 1)) || (|DELAY_LINE_OUT_OF_RANGE)) state_d = S_CENTER;
                else                                                                  state_d = S_STEP;
            end
            S_STEP: begin
                tap_d   = tap_q + TAP_BITS'(1);
                state_d = S_SETTLE;
            end
            S_CENTER: begin
                for (int i = 0; i < NUM_DQ; i++) begin
                    cur_tap_d[i] = tap_q;
                    if (best_len_q[i] == '0) begin
                        err_d[i]    = 1'b1;
                        centre_d[i] = '0;
                    end else begin
                        centre_d[i] = best_start_q[i]
                                    + TAP_BITS'((best_len_q[i] - LEN_W'(1)) >> 1);
                    end
                end
                state_d = S_WALK;
            end
            S_WALK: begin
                for (int i = 0; i < NUM_DQ; i++) begin
                    if (cur_tap_q[i] > centre_q[i]) cur_tap_d[i] = cur_tap_q[i] - TAP_BITS'(1);
                end
                state_d = S_GAP;
            end
            S_GAP: begin
                for (int i = 0; i < NUM_DQ; i++) begin
                    if (cur_tap_q[i] != centre_q[i]) all_at = 1'b0;
                end
                state_d = all_at ? S_DONE : S_WALK;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered
        case (state_d)
            S_LOAD: load_d = '1;
            S_STEP: begin
                move_d = '1;
                dir_d  = '1;
            end
            S_WALK: begin
                for (int i = 0; i < NUM_DQ; i++) move_d[i] = (cur_tap_d[i] > centre_d[i]);
            end
            S_SETTLE: begin
                if (state_q == S_LOAD || state_q == S_STEP) clear_d = '1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tap_q   <= '0;
            pass_q  <= '0;
            err_q   <= '0;
            load_q  <= '0;
            move_q  <= '0;
            dir_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= '0;
            for (int i = 0; i < NUM_DQ; i++) begin
                run_start_q[i]  <= '0;
                run_len_q[i]    <= '0;
                best_start_q[i] <= '0;
                best_len_q[i]   <= '0;
                centre_q[i]     <= '0;
                cur_tap_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            load_q  <= load_d;
            move_q  <= move_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clear_q <= clear_d;
            for (int i = 0; i < NUM_DQ; i++) begin
                run_start_q[i]  <= run_start_d[i];
                run_len_q[i]    <= run_len_d[i];
                best_start_q[i] <= best_start_d[i];
                best_len_q[i]   <= best_len_d[i];
                centre_q[i]     <= centre_d[i];
                cur_tap_q[i]    <= cur_tap_d[i];
            end
        end
    end

    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign TRAIN_BUSY           = busy_q;
    assign TRAIN_DONE           = done_q;
    assign TRAIN_ERR            = err_q;
`ifdef READ_TRAINING_EYE_MONITOR_EN
    assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
`endif

    for (genvar g = 0; g < NUM_DQ; g++) begin : g_ctap
        assign CENTER_TAP[g*TAP_BITS +: TAP_BITS] = centre_q[g];
    end

endmodule
